// File: rtl/text_console.sv
// Character-stream front end: decodes a byte stream into tile-memory cell writes
// and keeps a text cursor; runs a full-screen clear after reset and on form feed.
module text_console #(
  parameter int          COLS     = 80,
  parameter int          ROWS     = 60,
  parameter int          ADDR_W   = 13,
  parameter logic [7:0]  CLR_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy
);

  localparam logic [6:0]        LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        COLS_B    = 8'(COLS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_n;
  logic [6:0]        col, col_n;
  logic [5:0]        row, row_n;
  logic [ADDR_W-1:0] line_base, base_n;
  logic [ADDR_W-1:0] clr_cnt, cnt_n;
  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic [ADDR_W-1:0] cell_addr;
  logic [7:0]        tab_col;
  logic              accept;
  logic              adv_row;

  assign in_ready   = (state == IDLE);
  assign busy       = (state == CLEAR);
  assign cursor_col = col;
  assign cursor_row = row;
  assign accept     = in_valid && (state == IDLE);
  assign cell_addr  = line_base + ADDR_W'(col);
  // Next tab stop: round up to the next multiple of 8, one bit wider to catch overflow.
  assign tab_col    = {1'b0, col | 7'd7} + 8'd1;

  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    base_n    = line_base;
    cnt_n     = clr_cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    adv_row   = 1'b0;

    case (state)
      CLEAR: begin
        wr_en_n   = 1'b1;
        wr_addr_n = clr_cnt;
        wr_data_n = CLR_CHAR;
        if (clr_cnt == LAST_CELL) begin
          state_n = IDLE;
          cnt_n   = '0;
          col_n   = '0;
          row_n   = '0;
          base_n  = '0;
        end else begin
          cnt_n = clr_cnt + 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (in_data >= 8'h20 && in_data <= 8'h7E) begin
            wr_en_n   = 1'b1;
            wr_addr_n = cell_addr;
            wr_data_n = in_data;
            if (col == LAST_COL) begin
              col_n   = '0;
              adv_row = 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end else if (in_data == 8'h0D) begin
            col_n = '0;
          end else if (in_data == 8'h0A) begin
            col_n   = '0;
            adv_row = 1'b1;
          end else if (in_data == 8'h08) begin
            if (col != '0) begin
              col_n     = col - 1'b1;
              wr_en_n   = 1'b1;
              wr_addr_n = cell_addr - 1'b1;
              wr_data_n = CLR_CHAR;
            end
          end else if (in_data == 8'h09) begin
            if (tab_col >= COLS_B) begin
              col_n   = '0;
              adv_row = 1'b1;
            end else begin
              col_n = tab_col[6:0];
            end
          end else if (in_data == 8'h0C) begin
            state_n = CLEAR;
            cnt_n   = '0;
          end
        end
      end
    endcase

    // Row change keeps line_base = row*COLS without a multiplier; no scrolling.
    if (adv_row) begin
      if (row == LAST_ROW) begin
        row_n  = '0;
        base_n = '0;
      end else begin
        row_n  = row + 1'b1;
        base_n = line_base + COLS_A;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_cnt   <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      clr_cnt   <= cnt_n;
      col       <= col_n;
      row       <= row_n;
      line_base <= base_n;
      wr_en     <= wr_en_n;
      wr_addr   <= wr_addr_n;
      wr_data   <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: directed scenarios plus random byte traffic checked
// against a cursor/screen model built from plain integer arithmetic.
module tb_text_console;
  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int CELLS  = COLS * ROWS;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic              busy;

  int nchk = 0;
  int nerr = 0;
  int mcol = 0;
  int mrow = 0;

  text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .CLR_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, 32'(cursor_col), 32'(mcol));
    chk({tag, "_row"}, 32'(cursor_row), 32'(mrow));
  endtask

  // Clear sequence: n cycles of blanking writes starting at address 0.
  task automatic run_clear(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("clr_write", {wr_en, 19'(wr_addr), wr_data}, {1'b1, 19'(i), 8'h20});
      chk("clr_ready", {31'd0, in_ready}, {31'd0, (i == CELLS - 1)});
      if (i == CELLS - 1) begin
        chk("clr_busy", {31'd0, busy}, 32'd0);
        mcol = 0;
        mrow = 0;
        chk_cursor("clr_end");
      end
    end
  endtask

  task automatic model_next_row();
    mrow = (mrow + 1) % ROWS;
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    bit exp_en;
    int exp_addr;
    logic [7:0] exp_data;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    exp_en   = 1'b0;
    exp_addr = 0;
    exp_data = 8'h00;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_en = 1'b1; exp_addr = mrow * COLS + mcol; exp_data = b;
      mcol++;
      if (mcol == COLS) begin mcol = 0; model_next_row(); end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0; model_next_row();
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        exp_en = 1'b1; exp_addr = mrow * COLS + mcol; exp_data = 8'h20;
      end
    end else if (b == 8'h09) begin
      mcol = (mcol / 8 + 1) * 8;
      if (mcol >= COLS) begin mcol = 0; model_next_row(); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (b == 8'h0C) begin
      chk({tag, "_ff_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_ff_busy"}, {31'd0, busy}, 32'd1);
    end else if (exp_en) begin
      chk({tag, "_wr"}, {wr_en, 19'(wr_addr), wr_data}, {1'b1, 19'(exp_addr), exp_data});
      chk_cursor(tag);
    end else begin
      chk({tag, "_nowr"}, {31'd0, wr_en}, 32'd0);
      chk_cursor(tag);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    chk("idle_nowr", {31'd0, wr_en}, 32'd0);
    chk_cursor("idle");
  endtask

  initial begin
    int r;
    logic [7:0] b;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk); #1;
    chk("rst_wr", {wr_en, 19'(wr_addr), wr_data}, 28'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk_cursor("rst");
    rst = 1'b0;
    run_clear(CELLS);
    idle_cycle();

    send(8'h41, "A");
    send(8'h42, "B");
    for (int i = 0; i < 77; i++) send(8'($urandom_range(32'h20, 32'h7E)), "fill0");
    chk("at79_col", 32'(cursor_col), 32'd79);
    send(8'h5A, "wrap_col");
    send(8'h41, "row1");

    for (int i = 0; i < 58; i++) send(8'h0A, "lf");
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32'h20, 32'h7E)), "fill59");
    chk("at59_row", 32'(cursor_row), 32'd59);
    send(8'h0A, "lf_wrap");
    send(8'h08, "bs_col0");
    send(8'h43, "C");
    send(8'h08, "bs_back");

    send(8'h0A, "lf"); send(8'h0A, "lf");
    for (int i = 0; i < 3; i++) send(8'h2E, "dot");
    send(8'h09, "tab3");
    for (int i = 0; i < 8; i++) send(8'h09, "tab");
    for (int i = 0; i < 6; i++) send(8'h2D, "dash");
    chk("at78_col", 32'(cursor_col), 32'd78);
    send(8'h09, "tab78");
    send(8'h0D, "cr");
    send(8'h00, "ign00");
    send(8'h7F, "ign7f");
    send(8'h80, "ign80");

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14) b = 8'($urandom_range(32'h20, 32'h7E));
      else if (r == 14) b = 8'h0D;
      else if (r == 15) b = 8'h0A;
      else if (r == 16) b = 8'h08;
      else if (r == 17) b = 8'h09;
      else if (r == 18) begin
        case ($urandom_range(0, 3))
          0: b = 8'h00;
          1: b = 8'h1B;
          2: b = 8'h7F;
          default: b = 8'hFF;
        endcase
      end else b = 8'h00;
      if (r == 19) idle_cycle();
      else send(b, "rnd");
    end

    send(8'h0C, "ff_mid");
    run_clear(1001);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst2_wr", {31'd0, wr_en}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    run_clear(CELLS);
    send(8'h55, "held");

    send(8'h0C, "ff");
    run_clear(CELLS);
    idle_cycle();
    send(8'h58, "post_ff");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
